// File: rtl/morse_seq_pkg.sv
// Shared types and Morse timing constants for the tone sequencer.
package morse_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TONE,
        S_GAP,
        S_CHAR_GAP,
        S_CLICK
    } state_e;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MAX_ELEMS      = 8;

    typedef struct packed {
        logic [3:0] len;
        logic [7:0] bits;
    } sym_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > 4'(MAX_ELEMS)) ? 4'(MAX_ELEMS) : len;
    endfunction

endpackage

// File: rtl/morse_tone_sequencer_if.sv
// Symbol push channel between the UI controller (master) and the sequencer (slave).
interface morse_tone_sequencer_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [3:0] sym_len;
    logic [7:0] sym_bits;

    modport master (output sym_valid, sym_len, sym_bits, input sym_ready);
    modport slave  (input sym_valid, sym_len, sym_bits, output sym_ready);
endinterface

// File: rtl/morse_sym_fifo.sv
// Small synchronous symbol queue with flush; full/empty from wrap-bit pointers.
module morse_sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/morse_tone_sequencer.sv
// Plays queued Morse symbols on the piezo; MORSE_SEQ_CLICK_EN adds idle key-click beeps.
module morse_tone_sequencer
    import morse_seq_pkg::*;
#(
    parameter int          UNIT_CYCLES  = 3_000_000,
    parameter logic [31:0] TONE_DIV     = 32'd25_000,
    parameter logic [31:0] CLICK_DIV    = 32'd12_500,
    parameter int          CLICK_CYCLES = 500_000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    morse_tone_sequencer_if.slave        sym,
    input  logic                         click_req,
    input  logic                         flush,
    output logic                         piezo_en,
    output logic [31:0]                  piezo_freq,
    output logic                         busy,
    output logic                         done
);
    localparam int UCW = $clog2(UNIT_CYCLES + 1);

    state_e         state, state_nxt;
    logic [UCW-1:0] unit_cnt, unit_cnt_nxt;
    logic [2:0]     units_left, units_nxt;
    logic [3:0]     len_q;
    logic [7:0]     bits_q;
    logic [2:0]     idx;
    logic           push, pop, full, empty, idx_inc, done_nxt;
    logic           unit_end, timed, timed_end, last_elem;
    sym_t           head;

    // Ready ignores a same-cycle pop so a full queue never takes a bypass write.
    assign sym.sym_ready = !full && !flush;
    assign push          = sym.sym_valid && sym.sym_ready;

    morse_sym_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(sym_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({clamp_len(sym.sym_len), sym.sym_bits}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign unit_end  = (unit_cnt == UCW'(UNIT_CYCLES - 1));
    assign timed     = (state == S_TONE) || (state == S_GAP) || (state == S_CHAR_GAP);
    assign timed_end = unit_end && (units_left == 3'd1);
    assign last_elem = ({1'b0, idx} == len_q - 4'd1);
    assign busy      = (state != S_IDLE) || !empty;

`ifdef MORSE_SEQ_CLICK_EN
    localparam int CCW = $clog2(CLICK_CYCLES + 1);
    logic [CCW-1:0] click_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_cnt  <= '0;
            piezo_freq <= TONE_DIV;
        end else begin
            click_cnt  <= (state == S_CLICK) ? click_cnt + CCW'(1) : '0;
            piezo_freq <= (state_nxt == S_CLICK) ? CLICK_DIV : TONE_DIV;
        end
    end
`else
    logic unused_click;
    assign unused_click = click_req ^ (|CLICK_DIV) ^ (CLICK_CYCLES != 0);
    assign piezo_freq   = TONE_DIV;
`endif

    always_comb begin
        state_nxt    = state;
        unit_cnt_nxt = '0;
        units_nxt    = units_left;
        pop          = 1'b0;
        idx_inc      = 1'b0;
        done_nxt     = 1'b0;
        if (timed && unit_end) units_nxt = units_left - 3'd1;
        else if (timed)        unit_cnt_nxt = unit_cnt + UCW'(1);

        case (state)
            S_IDLE: begin
                if (!empty) state_nxt = S_LOAD;
`ifdef MORSE_SEQ_CLICK_EN
                else if (click_req) state_nxt = S_CLICK;
`endif
            end
            S_LOAD: begin
                pop = 1'b1;
                if (head.len == 4'd0) begin
                    state_nxt = S_CHAR_GAP;
                    units_nxt = 3'(WORD_GAP_UNITS);
                end else begin
                    state_nxt = S_TONE;
                    units_nxt = head.bits[0] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
                end
            end
            S_TONE: begin
                if (timed_end) begin
                    state_nxt = last_elem ? S_CHAR_GAP : S_GAP;
                    units_nxt = last_elem ? 3'(CHAR_GAP_UNITS) : 3'(ELEM_GAP_UNITS);
                end
            end
            S_GAP: begin
                if (timed_end) begin
                    state_nxt = S_TONE;
                    idx_inc   = 1'b1;
                    units_nxt = bits_q[idx + 3'd1] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
                end
            end
            S_CHAR_GAP: begin
                if (timed_end) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`ifdef MORSE_SEQ_CLICK_EN
            S_CLICK: begin
                if (click_cnt == CCW'(CLICK_CYCLES - 1)) state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        if (flush) begin
            state_nxt    = S_IDLE;
            unit_cnt_nxt = '0;
            pop          = 1'b0;
            done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            unit_cnt   <= '0;
            units_left <= '0;
            len_q      <= '0;
            bits_q     <= '0;
            idx        <= '0;
            piezo_en   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            unit_cnt   <= unit_cnt_nxt;
            units_left <= units_nxt;
            done       <= done_nxt;
            // Output follows next state so the tone lines up with the TONE/CLICK cycles.
            piezo_en   <= (state_nxt == S_TONE) || (state_nxt == S_CLICK);
            if (state == S_LOAD) begin
                len_q  <= head.len;
                bits_q <= head.bits;
                idx    <= '0;
            end else if (idx_inc) begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_morse_tone_sequencer.sv
// Randomized bench for morse_tone_sequencer against a per-cycle timeline model.
module tb_morse_tone_sequencer;
    localparam int          U     = 4;
    localparam int          CC    = 3;
    localparam int          DEPTH = 4;
    localparam int          NC    = 8192;
    localparam logic [31:0] TD    = 32'd25_000;
    localparam logic [31:0] CD    = 32'd12_500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        click_req, flush;
    logic        piezo_en, busy, done;
    logic [31:0] piezo_freq;

    morse_tone_sequencer_if sif();

    morse_tone_sequencer #(
        .UNIT_CYCLES(U), .TONE_DIV(TD), .CLICK_DIV(CD),
        .CLICK_CYCLES(CC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sym(sif), .click_req(click_req), .flush(flush),
        .piezo_en(piezo_en), .piezo_freq(piezo_freq), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks, errors, cyc, p_idle, n_done;
    bit acc;
    bit exp_en [NC];
    bit exp_click [NC];
    bit exp_done [NC];
    bit nonidle [NC];
    int pt[$];
    int pl[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int occ(input int cc);
        int n = 0;
        foreach (pt[k]) if (pt[k] < cc && pl[k] >= cc) n++;
        return n;
    endfunction

    function automatic void mark(input int kind, input int lo, input int hi);
        for (int x = lo; x < hi; x++) begin
            if (x >= 0 && x < NC) begin
                case (kind)
                    0: exp_en[x] = 1'b1;
                    1: nonidle[x] = 1'b1;
                    2: exp_click[x] = 1'b1;
                    default: exp_done[x] = 1'b1;
                endcase
            end
        end
    endfunction

    function automatic void clear_from(input int lo);
        for (int x = lo; x < NC; x++) begin
            if (x >= 0) begin
                exp_en[x] = 1'b0; exp_click[x] = 1'b0;
                exp_done[x] = 1'b0; nonidle[x] = 1'b0;
            end
        end
    endfunction

    // Idle-check cycle, LOAD cycle, then elements and gaps in whole units.
    function automatic void sched_sym(input logic [3:0] len, input logic [7:0] bits);
        int i, ld, t, n, d;
        i  = (cyc + 1 > p_idle) ? cyc + 1 : p_idle;
        ld = i + 1;
        t  = ld + 1;
        n  = (len > 4'd8) ? 8 : int'(len);
        if (n == 0) t += 7 * U;
        else begin
            for (int k = 0; k < n; k++) begin
                d = bits[k] ? 3 : 1;
                mark(0, t, t + d * U);
                t += d * U;
                t += ((k == n - 1) ? 3 : 1) * U;
            end
        end
        mark(1, ld, t);
        mark(3, t, t + 1);
        p_idle = t;
        pt.push_back(cyc);
        pl.push_back(ld);
    endfunction

    function automatic void sched_click();
        mark(0, cyc + 1, cyc + 1 + CC);
        mark(2, cyc + 1, cyc + 1 + CC);
        mark(1, cyc + 1, cyc + 1 + CC);
        p_idle = cyc + 1 + CC;
    endfunction

    function automatic void model_flush();
        clear_from(cyc + 1);
        while (pl.size() > 0 && pl[pl.size() - 1] > cyc) begin
            void'(pl.pop_back());
            void'(pt.pop_back());
        end
        p_idle = cyc + 1;
    endfunction

    task automatic step(input logic v, input logic [3:0] len, input logic [7:0] bits,
                        input logic ck, input logic fl);
        bit er, eb;
        int o;
        sif.sym_valid = v; sif.sym_len = len; sif.sym_bits = bits;
        click_req = ck; flush = fl;
        #2;
        while (pl.size() > 0 && pl[0] < cyc) begin
            void'(pl.pop_front());
            void'(pt.pop_front());
        end
        o  = occ(cyc);
        er = !fl && (o < DEPTH);
        eb = nonidle[cyc] || (o > 0);
        chk("piezo_en", piezo_en, exp_en[cyc]);
        chk("piezo_freq", piezo_freq, exp_click[cyc] ? CD : TD);
        chk("done", done, exp_done[cyc]);
        chk("busy", busy, eb);
        chk("sym_ready", sif.sym_ready, er);
        if (done === 1'b1) n_done++;
        acc = 1'b0;
        if (fl) model_flush();
        else begin
`ifdef MORSE_SEQ_CLICK_EN
            if (ck && !eb) sched_click();
`endif
            if (v && er) begin
                sched_sym(len, bits);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic push_sym(input logic [3:0] len, input logic [7:0] bits, output int waited);
        waited = 0;
        step(1'b1, len, bits, 1'b0, 1'b0);
        while (!acc && waited < 1000) begin
            waited++;
            step(1'b1, len, bits, 1'b0, 1'b0);
        end
        if (!acc) chk("push_timeout", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        int w, w4, base;
        logic       r_pend, fl, ck;
        logic [3:0] r_len;
        logic [7:0] r_bits;
        checks = 0; errors = 0; cyc = 0; p_idle = 0; n_done = 0; acc = 1'b0;
        rst_n = 1'b0; click_req = 1'b0; flush = 1'b0;
        sif.sym_valid = 1'b0; sif.sym_len = '0; sif.sym_bits = '0;
        #3;
        chk("rst_piezo_en", piezo_en, 0);
        chk("rst_piezo_freq", piezo_freq, TD);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sym_ready", sif.sym_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 'A' then a word space
        push_sym(4'd2, 8'b10, w);
        idle(50);
        chk("a_done_count", n_done, 1);
        push_sym(4'd0, 8'd0, w);
        idle(35);
        chk("word_done_count", n_done, 2);

        // fill the queue behind a long symbol; the fifth push must wait
        push_sym(4'd8, 8'hff, w);
        idle(4);
        w4 = 0;
        push_sym(4'd3, 8'h00, w); w4 += w;
        push_sym(4'd3, 8'h07, w); w4 += w;
        push_sym(4'd1, 8'h00, w); w4 += w;
        push_sym(4'd1, 8'h01, w); w4 += w;
        chk("four_pushes_no_wait", w4, 0);
        push_sym(4'd12, 8'h5a, w);
        chk("fifth_push_waited", {31'd0, w > 0}, 1);
        idle(1000);
        chk("queue_done_count", n_done, 8);

        // flush during a dash, with a competing push
        push_sym(4'd1, 8'h01, w);
        push_sym(4'd2, 8'h00, w);
        push_sym(4'd3, 8'h05, w);
        idle(4);
        step(1'b1, 4'd3, 8'h05, 1'b0, 1'b1);
        idle(60);
        chk("flush_no_done", n_done, 8);

        // key click when idle, then one during a tone
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        idle(8);
        push_sym(4'd1, 8'h01, w);
        idle(5);
        step(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
        idle(30);

        r_pend = 1'b0; r_len = '0; r_bits = '0;
        for (int r = 0; r < 3000; r++) begin
            if (!r_pend && $urandom_range(0, 5) == 0) begin
                r_pend = 1'b1;
                r_len  = 4'($urandom_range(0, 12));
                r_bits = 8'($urandom);
            end
            fl = ($urandom_range(0, 299) == 0);
            ck = ($urandom_range(0, 24) == 0);
            step(r_pend, r_len, r_bits, ck, fl);
            if (acc) r_pend = 1'b0;
        end
        idle(20);

        // asynchronous reset in the middle of a tone
        push_sym(4'd1, 8'h01, w);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_piezo_en", piezo_en, 0);
        chk("rst_mid_piezo_freq", piezo_freq, TD);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_sym_ready", sif.sym_ready, 1);
        clear_from(cyc);
        pt.delete();
        pl.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
        p_idle = cyc;
        base = n_done;
        push_sym(4'd2, 8'b10, w);
        idle(50);
        chk("post_reset_done_count", n_done - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_tone_sequencer.md
Name: morse_tone_sequencer

Overview:
- Schedules the shared piezo tone resource. Plays queued Morse symbols as timed dot/dash tones and gaps, and optionally inserts short key-click beeps.
- Sits between the UI controller, which pushes symbols and click requests, and the piezo driver, which consumes the piezo_en and piezo_freq outputs.
- Owns all Morse timing, so the UI only enqueues symbols.

Parameters:
- UNIT_CYCLES, 3_000_000: clock cycles per Morse time unit (60 ms at 50 MHz); must be >= 1.
- TONE_DIV, 32'd25_000: piezo_freq value driven during symbol tones.
- CLICK_DIV, 32'd12_500: piezo_freq value driven during a key click.
- CLICK_CYCLES, 500_000: key-click duration in cycles; must be >= 1.
- FIFO_DEPTH, 4: symbol queue depth; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sym_valid  in  1  symbol push request
- sym_ready  out  1  queue can accept a symbol (not full, and flush not asserted)
- sym_len  in  4  element count, 0..8; 0 = word space; values >8 are clamped to 8
- sym_bits  in  8  elements played LSB first; 1 = dash, 0 = dot
- click_req  in  1  single-cycle key-click request
- flush  in  1  abort playback and empty the queue
- piezo_en  out  1  tone enable (registered)
- piezo_freq  out  32  tone divider (registered)
- busy  out  1  state != IDLE or queue not empty
- done  out  1  one-cycle pulse when a symbol's trailing gap completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: piezo_en=0, piezo_freq=TONE_DIV, done=0, busy=0, queue empty, state IDLE. sym_ready=1 after reset.
- Handshake:
  - A push occurs when sym_valid & sym_ready; the symbol is written that cycle.
  - There is no full-queue bypass: sym_ready is derived from the pre-pop occupancy.
  - Holding sym_valid while sym_ready=0 is legal; the data is held until accepted.
- State machine: IDLE, LOAD, TONE, GAP, CHAR_GAP, CLICK.
  - IDLE: if the queue is not empty, go to LOAD. This takes priority over a click request in the same cycle.
  - LOAD: pop the head and latch len and bits; element index = 0.
    - len=0: go to CHAR_GAP with 7 units.
    - Otherwise go to TONE.
  - TONE: piezo_en=1 and piezo_freq=TONE_DIV for 1 unit (dot) or 3 units (dash).
    - After the last element go to CHAR_GAP with 3 units; otherwise go to GAP.
  - GAP: piezo_en=0 for 1 unit, then TONE for the next element.
  - CHAR_GAP: piezo_en=0 for the latched unit count.
    - At exit, pulse done for 1 cycle and return to IDLE.
    - The next queued symbol then goes through LOAD.
- Timing:
  - A unit counter runs 0..UNIT_CYCLES-1, and a unit-count register counts down.
  - Every timed state lasts exactly N*UNIT_CYCLES cycles, measured by piezo_en levels.
- Latency: a push into an empty, idle block in cycle T gives piezo_en=1 first in cycle T+3. The path is the queue write, IDLE->LOAD, LOAD->TONE, then the registered output.
- Flush: takes effect next cycle.
  - Queue cleared, state IDLE, piezo_en=0, no done pulse.
  - Flush beats a simultaneous push, which is not accepted, and a simultaneous click.
- Reset mid-operation: everything returns to its reset value asynchronously, and a partially played symbol is lost.

Optional Feature:
- Macro: MORSE_SEQ_CLICK_EN.
- Defined:
  - click_req in IDLE with an empty queue goes to CLICK: piezo_en=1, piezo_freq=CLICK_DIV for CLICK_CYCLES, then back to IDLE with no done pulse.
  - click_req in any other state is dropped.
- Undefined: the CLICK state, counter and CLICK_DIV path are not built; click_req is ignored; piezo_freq is constant TONE_DIV.

Decomposition:
- Package morse_seq_pkg holds:
  - the state enum;
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7;
  - MAX_ELEMS=8.
- Sub-module morse_sym_fifo: a synchronous FIFO of 12 bits (len + bits) with push, pop, flush, full and empty.

Test Plan (UNIT_CYCLES=4, CLICK_CYCLES=3, FIFO_DEPTH=4):
- Push len=2, bits=8'b10 ('A'): piezo_en high 4, low 4, high 12, low 12 cycles; done pulses once; busy then 0.
- Push len=0: piezo_en stays 0 for 28 cycles, then done pulses.
- Five back-to-back pushes with playback running: 4 accepted; sym_ready=0 on the 5th until the first pop; all 5 play in order.
- Flush during a dash: piezo_en=0 the next cycle, busy=0, no done pulse, sym_ready=1; queued symbols never play.
- With MORSE_SEQ_CLICK_EN, click_req in idle: piezo_en=1 for 3 cycles with piezo_freq=CLICK_DIV. click_req during a TONE has no effect on the outputs.
- Assert rst_n=0 mid-tone: piezo_en=0, piezo_freq=TONE_DIV and busy=0 immediately, without waiting for a clock edge.
